recip_scaler_pipe: RTL and testbench
====================================

Name: recip_scaler_pipe

Overview:
- Pipelined successor to the fixed 8-entry reciprocal ROM used by the affine motion-vector path.
- Computes MV = delta * 1/(2^k - 1) in fixed point with valid/ready flow control.
- Reciprocal table is generated at elaboration from parameters, not hand-coded.
- Sits between the control-point delta subtractor and the sub-block MV accumulator.

Parameters:
- DATA_W, 16, signed width of in_delta and out_mv.
- FRAC_W, 8, fractional bits of the reciprocal coefficient (unsigned Q0.FRAC_W).
- LOG2_W, 4, width of in_log2.
- MIN_LOG2, 2, smallest supported log2 block size k.
- MAX_LOG2, 7, largest supported log2 block size k (must be < 2^LOG2_W and <= 30).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block accepts input this cycle.
- in_delta  in  DATA_W  signed CPMV difference.
- in_log2  in  LOG2_W  k = log2 of block width/height.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_mv  out  DATA_W  signed scaled result.
- out_err  out  1  k outside [MIN_LOG2, MAX_LOG2]; out_mv forced to 0.

Behaviour:
- Coefficient table: coef(k) = floor(2^FRAC_W / (2^k - 1)) for MIN_LOG2 <= k <= MAX_LOG2, else 0.
  - Constant function, FRAC_W bits unsigned.
  - FRAC_W = 8 gives k = 2..7 -> 85, 36, 17, 8, 4, 2.
- Stage S1 (registered): captures in_delta, coef(in_log2), and err = (k out of range) on handshake in_valid && in_ready.
- Stage S2 (registered): computes signed product delta * {1'b0, coef}, width DATA_W + FRAC_W + 1.
  - Rounds per the Optional Feature, then arithmetic right shift by FRAC_W.
  - Result is truncated to DATA_W. No overflow is possible since coef <= 2^FRAC_W / 3.
  - If err, out_mv = 0 and out_err = 1.
- Latency: exactly 2 cycles from input handshake to out_valid when unstalled. Throughput is 1 sample/cycle.
- Flow control, standard 2-deep pipeline:
  - s2_adv = !out_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready = s1_adv, combinational from out_ready; no skid buffer.
- Stall: while out_valid && !out_ready, out_mv, out_err and out_valid hold stable. S1 holds its sample and in_ready = 0.
- Simultaneous events:
  - out handshake and in handshake in the same cycle are legal.
  - The pipeline shifts without a bubble.
- Reset:
  - rst = 1 clears s1_valid, out_valid, out_mv = 0, out_err = 0 on the next edge, including mid-stall.
  - In-flight samples are discarded.
  - in_ready = 1 during and after reset.
- in_delta and in_log2 are ignored when in_valid = 0.

Optional Feature:
- Macro RECIP_ROUND_EN.
  - Defined: add 2^(FRAC_W-1) to the product before the arithmetic shift (round half toward +inf).
  - Undefined: plain arithmetic shift (floor).
- Table, latency and handshake are identical in both builds.

Test Plan:
- Defaults, delta = 96, k = 2 -> out_mv = 32 with RECIP_ROUND_EN (8288 >>> 8), 31 without; out_valid 2 cycles after the handshake; out_err = 0.
- delta = -96, k = 2 -> -32 in both builds; delta = 1000, k = 7 -> 8 rounded, 7 truncated.
- k = 1, then k = 8, with delta = 500 -> out_mv = 0 and out_err = 1 for each. The next sample (delta = 100, k = 5) -> 3 with out_err = 0.
- Back-to-back stream of 8 samples with out_ready = 1 -> 8 results on consecutive cycles, in order, no bubbles.
- out_ready = 0 for 5 cycles while 3 samples are offered:
  - out_mv stays stable; in_ready drops after 2 samples are held.
  - After release, all 3 emerge in order with none lost or duplicated.
- Assert rst for 1 cycle while both stages are full and stalled -> next cycle out_valid = 0, out_mv = 0, in_ready = 1; a new sample appears 2 cycles after acceptance.

Source files
------------

// File: rtl/recip_scaler_pipe.sv
// recip_scaler_pipe: two-stage pipeline computing MV = delta * 1/(2^k - 1), valid/ready handshake.
// Define RECIP_ROUND_EN to round half toward +inf before the final shift; default floors.
module recip_scaler_pipe #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned FRAC_W   = 8,
  parameter int unsigned LOG2_W   = 4,
  parameter int unsigned MIN_LOG2 = 2,
  parameter int unsigned MAX_LOG2 = 7
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_delta,
  input  logic        [LOG2_W-1:0] in_log2,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_mv,
  output logic                     out_err
);

  localparam int unsigned PROD_W = DATA_W + FRAC_W + 1;
  localparam int unsigned TAB_N  = 1 << LOG2_W;

`ifdef RECIP_ROUND_EN
  localparam logic signed [PROD_W-1:0] RndBias = PROD_W'(1) << (FRAC_W - 1);
`else
  localparam logic signed [PROD_W-1:0] RndBias = '0;
`endif

  function automatic logic [FRAC_W-1:0] coef_f(input int unsigned k);
    longint unsigned num;
    longint unsigned den;
    if (k < MIN_LOG2 || k > MAX_LOG2) return '0;
    num = 64'd1 << FRAC_W;
    den = (64'd1 << k) - 64'd1;
    return FRAC_W'(num / den);
  endfunction

  // Constant lookup table, one entry per encodable k.
  logic [FRAC_W-1:0] coef_tab [TAB_N];
  logic              err_tab  [TAB_N];

  for (genvar g = 0; g < TAB_N; g++) begin : g_tab
    assign coef_tab[g] = coef_f(g);
    assign err_tab[g]  = (g < MIN_LOG2) || (g > MAX_LOG2);
  end

  logic                     s1_valid_q;
  logic signed [DATA_W-1:0] s1_delta_q;
  logic        [FRAC_W-1:0] s1_coef_q;
  logic                     s1_err_q;

  logic                     out_valid_q;
  logic signed [DATA_W-1:0] out_mv_q, out_mv_d;
  logic                     out_err_q;

  logic                     s1_adv, s2_adv;
  logic signed [PROD_W-1:0] prod, prod_adj;
  logic                     unused_prod_bits;

  assign s2_adv   = !out_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = s1_adv || rst;

  always_comb begin
    prod     = PROD_W'(s1_delta_q) * PROD_W'($signed({1'b0, s1_coef_q}));
    prod_adj = prod + RndBias;
    // Taking bits above FRAC_W equals an arithmetic shift followed by truncation.
    out_mv_d = s1_err_q ? '0 : prod_adj[FRAC_W +: DATA_W];
  end

  assign unused_prod_bits = ^{prod_adj[FRAC_W-1:0], prod_adj[PROD_W-1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_delta_q <= '0;
      s1_coef_q  <= '0;
      s1_err_q   <= 1'b0;
    end else if (s1_adv) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_delta_q <= in_delta;
        s1_coef_q  <= coef_tab[in_log2];
        s1_err_q   <= err_tab[in_log2];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_mv_q    <= '0;
      out_err_q   <= 1'b0;
    end else if (s2_adv) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_mv_q  <= out_mv_d;
        out_err_q <= s1_err_q;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_mv    = out_mv_q;
  assign out_err   = out_err_q;

endmodule

// File: tb/tb_recip_scaler_pipe.sv
// tb_recip_scaler_pipe: directed vectors with hand-computed results for recip_scaler_pipe.
// Expected values follow the RECIP_ROUND_EN setting of the build.
module tb_recip_scaler_pipe;

  localparam int DATA_W = 16;
  localparam int LOG2_W = 4;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_delta;
  logic        [LOG2_W-1:0] in_log2;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [DATA_W-1:0] out_mv;
  logic                     out_err;

  recip_scaler_pipe dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_delta (in_delta),
    .in_log2  (in_log2),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_mv   (out_mv),
    .out_err  (out_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int mv;
    bit err;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks    = 0;
  int   failures  = 0;
  bit   lat_en    = 1'b1;
  int   n_out     = 0;
  int   first_out = 0;
  int   last_out  = 0;

  task automatic check_val(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input int floor_val, input int round_val);
`ifdef RECIP_ROUND_EN
    return round_val;
`else
    return floor_val;
`endif
  endfunction

  // Holds in_valid until accepted; records the expected result at the handshake cycle.
  task automatic send(input int d, input int k, input int emv, input bit eerr);
    bit   hs;
    exp_t e;
    in_valid = 1'b1;
    in_delta = DATA_W'(d);
    in_log2  = LOG2_W'(k);
    hs = 1'b0;
    for (int i = 0; i < 40 && !hs; i++) begin
      @(negedge clk);
      hs = in_ready;
      if (hs) begin
        e.mv  = emv;
        e.err = eerr;
        e.cyc = cyc;
        exp_q.push_back(e);
      end
      @(posedge clk);
      #1;
    end
    check_val("accepted", int'(hs), 1);
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_delta = 16'sh7bad;
    in_log2  = 4'd1;
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && exp_q.size() > 0; i++) @(posedge clk);
    #1;
    check_val("drained", exp_q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Output monitor: every output handshake must match the oldest pending expectation.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      check_val("out_pending", int'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        check_val("out_mv", int'(out_mv), mon_e.mv);
        check_val("out_err", int'(out_err), int'(mon_e.err));
        if (lat_en) check_val("latency", cyc - mon_e.cyc, 2);
      end
      n_out++;
      if (n_out == 1) first_out = cyc;
      last_out = cyc;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

  int sd [8] = '{256, -256, 1024, -1, 300, -300, 32767, -32768};
  int sk [8] = '{2, 3, 4, 2, 6, 7, 2, 2};
  int sf [8] = '{85, -36, 68, -1, 4, -3, 10879, -10880};
  int sr [8] = '{85, -36, 68, 0, 5, -2, 10880, -10880};

  initial begin
    rst       = 1'b1;
    out_ready = 1'b1;
    idle();
    @(posedge clk);
    #1;
    check_val("rst_in_ready", int'(in_ready), 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check_val("rst_out_valid", int'(out_valid), 0);
    check_val("rst_out_mv", int'(out_mv), 0);
    check_val("rst_out_err", int'(out_err), 0);
    check_val("rst_in_ready_after", int'(in_ready), 1);

    // Single samples, rounding direction and large k
    send(96, 2, pick(31, 32), 1'b0);
    idle();
    drain();
    send(-96, 2, -32, 1'b0);
    send(1000, 7, pick(7, 8), 1'b0);
    idle();
    drain();

    // Out-of-range k, then a normal sample
    send(500, 1, 0, 1'b1);
    send(500, 8, 0, 1'b1);
    send(100, 5, 3, 1'b0);
    idle();
    drain();

    // Back-to-back stream
    n_out = 0;
    for (int i = 0; i < 8; i++) send(sd[i], sk[i], pick(sf[i], sr[i]), 1'b0);
    idle();
    drain();
    check_val("stream_count", n_out, 8);
    check_val("stream_no_bubble", last_out - first_out, 7);

    // Stall: three samples offered while downstream is blocked
    lat_en    = 1'b0;
    out_ready = 1'b0;
    send(96, 2, pick(31, 32), 1'b0);
    send(-96, 2, -32, 1'b0);
    fork
      send(1000, 7, pick(7, 8), 1'b0);
      begin
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          check_val("stall_in_ready", int'(in_ready), 0);
          check_val("stall_out_valid", int'(out_valid), 1);
          check_val("stall_out_mv", int'(out_mv), pick(31, 32));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    idle();
    drain();
    lat_en = 1'b1;

    // Reset while both stages are full and stalled
    out_ready = 1'b0;
    send(200, 3, 28, 1'b0);
    send(-200, 3, pick(-29, -28), 1'b0);
    idle();
    @(posedge clk);
    #1;
    check_val("full_in_ready", int'(in_ready), 0);
    rst = 1'b1;
    exp_q.delete();
    #1;
    check_val("midrst_in_ready", int'(in_ready), 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check_val("postrst_out_valid", int'(out_valid), 0);
    check_val("postrst_out_mv", int'(out_mv), 0);
    check_val("postrst_in_ready", int'(in_ready), 1);
    out_ready = 1'b1;
    send(100, 5, 3, 1'b0);
    idle();
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
